// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared types, constants and op-decode helpers for the iterative
//            RV64M multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd12,
        OP_DIVUW  = 4'd13,
        OP_REMW   = 4'd14,
        OP_REMUW  = 4'd15
    } mdu_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op[3:2] == 2'b00) || (op == OP_MUL_W_CODE());
    endfunction

    function automatic logic [3:0] OP_MUL_W_CODE();
        return 4'd8;
    endfunction

    // Codes 9-11 have op[2]=0, so they fall out of both the mul and div decode.
    function automatic logic is_div(input logic [3:0] op);
        return op[2];
    endfunction

    function automatic logic is_rem(input logic [3:0] op);
        return op[2] & op[1];
    endfunction

    function automatic logic is_word(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic is_signed_a(input logic [3:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(input logic [3:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_step
// Brief    : One combinational restoring-division iteration: shift in the next
//            dividend bit, trial-subtract the divisor, keep or restore.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_bit,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q_bit
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    // No borrow out of the 65-bit trial subtract means the divisor fit.
    assign o_q_bit   = ~w_diff[XLEN];
    assign o_rem     = o_q_bit ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_iter
// Brief    : Iterative RV64M MUL/DIV/REM unit (shift-add multiply, restoring
//            divide). MDU_FAST_MUL_EN selects a single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_iter
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_done,
    output logic [XLEN-1:0] result
);

    mdu_state_t        r_state;
    mdu_state_t        w_next_state;
    logic [3:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_opb;
    logic [XLEN-1:0]   r_result;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_word;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_a_ext;
    logic [XLEN-1:0]   w_b_ext;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_accept;
    logic              w_div0;
    logic              w_quick;
    logic [XLEN-1:0]   w_quick_res;
    logic              w_last;

    // ---------------- operand conditioning at accept ----------------
    assign w_word  = is_word(op);
    assign w_sa    = is_signed_a(op);
    assign w_sb    = is_signed_b(op);
    assign w_a_ext = w_word ? (w_sa ? sext_word(src_a[31:0]) : {{(XLEN-32){1'b0}}, src_a[31:0]})
                            : src_a;
    assign w_b_ext = w_word ? (w_sb ? sext_word(src_b[31:0]) : {{(XLEN-32){1'b0}}, src_b[31:0]})
                            : src_b;
    assign w_a_neg = w_sa & w_a_ext[XLEN-1];
    assign w_b_neg = w_sb & w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_accept = (r_state == IDLE) && in_valid && !flush;
    assign w_div0   = is_div(op) && (w_b_ext == '0);

`ifdef MDU_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa;
    logic signed [XLEN:0]     w_fb;
    logic signed [2*XLEN+1:0] w_fprod;
    logic [XLEN-1:0]          w_fast_res;

    assign w_fa    = {w_a_neg, w_a_ext};
    assign w_fb    = {w_b_neg, w_b_ext};
    assign w_fprod = w_fa * w_fb;

    always_comb begin
        w_fast_res = w_fprod[2*XLEN-1:XLEN];
        if (op == OP_MUL)
            w_fast_res = w_fprod[XLEN-1:0];
        else if (op == OP_MULW)
            w_fast_res = sext_word(w_fprod[31:0]);
    end

    assign w_quick = !(is_mul(op) || is_div(op)) || w_div0 || is_mul(op);
`else
    assign w_quick = !(is_mul(op) || is_div(op)) || w_div0;
`endif

    // Results that are known at accept and bypass the iterative datapath.
    always_comb begin
        w_quick_res = '0;
        if (w_div0)
            w_quick_res = is_rem(op) ? (w_word ? sext_word(src_a[31:0]) : src_a) : '1;
`ifdef MDU_FAST_MUL_EN
        else if (is_mul(op))
            w_quick_res = w_fast_res;
`endif
    end

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_div_rem;
    logic            w_q_bit;

    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});

    mdu_div_step u_div_step (
        .i_rem     (r_rem),
        .i_divisor (r_opb),
        .i_bit     (r_quo[XLEN-1]),
        .o_rem     (w_div_rem),
        .o_q_bit   (w_q_bit)
    );

    assign w_last = (r_cnt == (is_word(r_op) ? CNT_W'(XLEN/2 - 1) : CNT_W'(XLEN - 1)));

    // ---------------- sign fix and result select ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_div_pick;
    logic [XLEN-1:0]   w_final;

    assign w_prod     = r_neg_q ? -r_acc : r_acc;
    assign w_q        = r_neg_q ? -r_quo : r_quo;
    assign w_r        = r_neg_r ? -r_rem : r_rem;
    assign w_div_pick = is_rem(r_op) ? w_r : w_q;

    // A word product sits at [XLEN-1:XLEN/2] after only XLEN/2 right shifts.
    always_comb begin
        w_final = is_word(r_op) ? sext_word(w_div_pick[31:0]) : w_div_pick;
        if (is_mul(r_op)) begin
            case (r_op)
                OP_MUL:  w_final = w_prod[XLEN-1:0];
                OP_MULW: w_final = sext_word(w_prod[XLEN-1:XLEN/2]);
                default: w_final = w_prod[2*XLEN-1:XLEN];
            endcase
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_quick)
                        w_next_state = DONE;
                    else if (is_mul(op))
                        w_next_state = MUL;
                    else
                        w_next_state = DIV;
                end
            end
            MUL:     if (w_last) w_next_state = FIX;
            DIV:     if (w_last) w_next_state = FIX;
            FIX:     w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (flush && (r_state != IDLE))
            w_next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_opb   <= w_b_mag;
                        r_acc   <= {{XLEN{1'b0}}, w_a_mag};
                        r_rem   <= '0;
                        // Word dividends are pre-aligned so the next bit is always the MSB.
                        r_quo   <= w_word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
                        if (w_quick)
                            r_result <= w_quick_res;
                    end
                end
                MUL: begin
                    r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DIV: begin
                    r_rem <= w_div_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    if (!flush)
                        r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE);
    assign out_done = (r_state == DONE);
    assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mdu_iter
// Brief    : Self-checking bench for mdu_iter: vector table with a result
//            scoreboard, plus flush, back-to-back and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        flush;
    logic        out_done;
    logic [63:0] result;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

`ifdef MDU_FAST_MUL_EN
    localparam int LAT_MUL  = 1;
    localparam int LAT_MULW = 1;
`else
    localparam int LAT_MUL  = 66;
    localparam int LAT_MULW = 34;
`endif
    localparam int LAT_DIV  = 66;
    localparam int LAT_DIVW = 34;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    mdu_iter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .out_done (out_done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v);
        int          cycles;
        int          ready_hi;
        logic [63:0] e;
        op       = v.op;
        src_a    = v.a;
        src_b    = v.b;
        in_valid = 1'b1;
        exp_q.push_back(v.exp);
        step();
        in_valid = 1'b0;
        cycles   = 1;
        ready_hi = 0;
        while (!out_done && cycles < 200) begin
            if (in_ready) ready_hi++;
            step();
            cycles++;
        end
        e = exp_q.pop_front();
        if (!out_done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no out_done within %0d cycles, required latency %0d", v.name, cycles, v.lat);
        end else begin
            check({v.name, " result"}, result, e);
            check({v.name, " latency"}, 64'(cycles), 64'(v.lat));
            check({v.name, " in_ready while busy"}, 64'(ready_hi) + {63'b0, in_ready}, 64'd0);
            step();
            check({v.name, " single pulse"}, {63'b0, out_done}, 64'd0);
            check({v.name, " held result"}, result, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"MUL 7x-3",       4'd0,  64'd7, -64'sd3, 64'hFFFFFFFFFFFFFFEB, LAT_MUL};
        vecs[1]  = '{"MULHU ones",     4'd3,  '1, '1, 64'hFFFFFFFFFFFFFFFE, LAT_MUL};
        vecs[2]  = '{"MULH ones",      4'd1,  '1, '1, 64'h0, LAT_MUL};
        vecs[3]  = '{"DIV -7/2",       4'd4,  -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFD, LAT_DIV};
        vecs[4]  = '{"REM -7/2",       4'd6,  -64'sd7, 64'd2, 64'hFFFFFFFFFFFFFFFF, LAT_DIV};
        vecs[5]  = '{"DIVU by zero",   4'd5,  64'd123, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1};
        vecs[6]  = '{"REM ovf",        4'd6,  64'h8000000000000000, '1, 64'h0, LAT_DIV};
        vecs[7]  = '{"DIV ovf",        4'd4,  64'h8000000000000000, '1, 64'h8000000000000000, LAT_DIV};
        vecs[8]  = '{"DIVW ovf",       4'd12, 64'h0000000080000000, 64'h00000000FFFFFFFF, 64'hFFFFFFFF80000000, LAT_DIVW};
        vecs[9]  = '{"MULW",           4'd8,  64'h000000007FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, LAT_MULW};
        vecs[10] = '{"MULHSU -1x2",    4'd2,  '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, LAT_MUL};
        vecs[11] = '{"REMU 100/7",     4'd7,  64'd100, 64'd7, 64'd2, LAT_DIV};
        vecs[12] = '{"illegal op 9",   4'd9,  64'd55, 64'd3, 64'h0, 1};
        vecs[13] = '{"REMW -7/2",      4'd14, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, LAT_DIVW};
        vecs[14] = '{"DIVUW",          4'd13, 64'h00000000FFFFFFFF, 64'd2, 64'h000000007FFFFFFF, LAT_DIVW};
        vecs[15] = '{"REM by zero",    4'd6,  64'h1234, 64'd0, 64'h1234, 1};
        vecs[16] = '{"REMUW by zero",  4'd15, 64'hABCD000080000005, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000005, 1};
        vecs[17] = '{"MUL wide",       4'd0,  64'h0000000100000001, 64'h0000000100000001, 64'h0000000200000001, LAT_MUL};
        vecs[18] = '{"DIVW upper junk",4'd12, 64'hFFFFFFFF00000064, 64'h12345678FFFFFFF6, 64'hFFFFFFFFFFFFFFF6, LAT_DIVW};

        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = 4'd0;
        src_a    = '0;
        src_b    = '0;
        #1;
        check("reset in_ready", {63'b0, in_ready}, 64'd1);
        check("reset out_done", {63'b0, out_done}, 64'd0);
        check("reset result", result, 64'd0);
        step();
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) run_op(vecs[i]);

        // flush ten cycles into a DIV: no pulse, result untouched
        op       = 4'd4;
        src_a    = 64'd1000;
        src_b    = 64'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c < 10; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush in_ready", {63'b0, in_ready}, 64'd1);
        check("flush out_done", {63'b0, out_done}, 64'd0);
        check("flush result", result, vecs[NV-1].exp);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 80; c++) begin
                if (out_done) seen++;
                step();
            end
            check("flush no late done", 64'(seen), 64'd0);
        end

        // flush in IDLE must block a same-cycle accept
        op       = 4'd5;
        src_a    = 64'd5;
        src_b    = 64'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        check("idle flush blocks accept", {62'b0, in_ready, out_done}, 64'd2);
        in_valid = 1'b0;
        flush    = 1'b0;
        step();

        // in_valid held across DONE: second request accepted the cycle after DONE
        op       = 4'd5;
        src_a    = 64'd9;
        src_b    = 64'd0;
        in_valid = 1'b1;
        step();
        check("b2b first done", {63'b0, out_done}, 64'd1);
        check("b2b first result", result, 64'hFFFFFFFFFFFFFFFF);
        op = 4'd7;
        step();
        check("b2b idle gap", {62'b0, in_ready, out_done}, 64'd2);
        step();
        in_valid = 1'b0;
        check("b2b second done", {63'b0, out_done}, 64'd1);
        check("b2b second result", result, 64'd9);
        step();

        // asynchronous reset in the middle of a MUL
        op       = 4'd0;
        src_a    = 64'd5;
        src_b    = 64'd6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) step();
        #2 reset = 1'b1;
        #1;
        check("mid reset in_ready", {63'b0, in_ready}, 64'd1);
        check("mid reset out_done", {63'b0, out_done}, 64'd0);
        check("mid reset result", result, 64'd0);
        step();
        reset = 1'b0;
        step();
        run_op('{"MUL after reset", 4'd0, 64'd5, 64'd6, 64'd30, LAT_MUL});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
